// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor slice: game state
// encoding, default pixel width and the score counter width.
package sprite_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } game_state_t;

    localparam int PIX_W_DEF = 4;

    function automatic int score_w(input int n_aliens);
        return $clog2(n_aliens + 1);
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Bundle of per-pixel sprite inputs and compositor outputs between the
// sprite generators / dtg (master) and the compositor (slave).
interface sprite_compositor_if #(
    parameter int N_ALIENS   = 15,
    parameter int N_MISSILES = 8,
    parameter int N_BARRIERS = 4,
    parameter int PIX_W      = sprite_pkg::PIX_W_DEF
);
    localparam int SCORE_W = sprite_pkg::score_w(N_ALIENS);

    logic                   video_on_i;
    logic                   frame_start_i;
    logic [N_ALIENS-1:0]    alien_active_i;
    logic [PIX_W-1:0]       alien_pix_i;
    logic                   player_active_i;
    logic [PIX_W-1:0]       player_pix_i;
    logic [N_MISSILES-1:0]  missile_active_i;
    logic [PIX_W-1:0]       missile_pix_i;
    logic [N_BARRIERS-1:0]  barrier_active_i;
    logic [PIX_W-1:0]       barrier_pix_i;
    logic [PIX_W-1:0]       bg_pix_i;
    logic [PIX_W-1:0]       win_pix_i;
    logic [PIX_W-1:0]       lose_pix_i;
    logic                   landed_i;
    logic                   restart_i;

    logic [PIX_W-1:0]       pix_o;
    logic [N_ALIENS-1:0]    alive_o;
    logic [N_MISSILES-1:0]  missile_hit_o;
    logic [SCORE_W-1:0]     score_o;
    logic [1:0]             state_o;

    modport master (
        output video_on_i, frame_start_i, alien_active_i, alien_pix_i,
               player_active_i, player_pix_i, missile_active_i, missile_pix_i,
               barrier_active_i, barrier_pix_i, bg_pix_i, win_pix_i, lose_pix_i,
               landed_i, restart_i,
        input  pix_o, alive_o, missile_hit_o, score_o, state_o
    );

    modport slave (
        input  video_on_i, frame_start_i, alien_active_i, alien_pix_i,
               player_active_i, player_pix_i, missile_active_i, missile_pix_i,
               barrier_active_i, barrier_pix_i, bg_pix_i, win_pix_i, lose_pix_i,
               landed_i, restart_i,
        output pix_o, alive_o, missile_hit_o, score_o, state_o
    );

endinterface

// File: rtl/collision_unit.sv
// Missile/alien/barrier collision resolution: lowest-index priority pick,
// per-frame spent mask, alien alive register and missile retire pulses.
module collision_unit #(
    parameter int N_ALIENS   = 15,
    parameter int N_MISSILES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_en,
    input  logic                  frame_start,
    input  logic                  revive,
    input  logic [N_ALIENS-1:0]   alien_active,
    input  logic [N_MISSILES-1:0] missile_active,
    input  logic                  barrier_hit,
    output logic [N_ALIENS-1:0]   alive,
    output logic [N_MISSILES-1:0] missile_hit,
    output logic                  kill
);

    logic [N_ALIENS-1:0]   alive_q;
    logic [N_MISSILES-1:0] spent_q;
    logic [N_MISSILES-1:0] hit_q;
    logic [N_ALIENS-1:0]   alien_sel;
    logic [N_MISSILES-1:0] missile_sel;
    logic                  alien_any;
    logic                  missile_any;
    logic                  collide;

    // Only one alien and one missile take part per pixel; the rest are ignored.
    always_comb begin
        alien_sel   = '0;
        missile_sel = '0;
        alien_any   = 1'b0;
        missile_any = 1'b0;
        for (int k = 0; k < N_ALIENS; k++) begin
            if (!alien_any && alien_active[k] && alive_q[k]) begin
                alien_sel[k] = 1'b1;
                alien_any    = 1'b1;
            end
        end
        for (int m = 0; m < N_MISSILES; m++) begin
            if (!missile_any && missile_active[m] && !spent_q[m]) begin
                missile_sel[m] = 1'b1;
                missile_any    = 1'b1;
            end
        end
    end

    assign kill    = play_en && missile_any && alien_any;
    assign collide = play_en && missile_any && (alien_any || barrier_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q <= '1;
            spent_q <= '0;
            hit_q   <= '0;
        end else begin
            hit_q   <= collide ? missile_sel : '0;
            spent_q <= (frame_start ? '0 : spent_q) | (collide ? missile_sel : '0);
            if (revive) begin
                alive_q <= '1;
            end else if (kill) begin
                alive_q <= alive_q & ~alien_sel;
            end
        end
    end

    assign alive       = alive_q;
    assign missile_hit = hit_q;

endmodule

// File: rtl/sprite_compositor.sv
// Game-state FSM, kill score and layer compositor producing one registered
// grey-level pixel per clock.
module sprite_compositor #(
    parameter int N_ALIENS   = 15,
    parameter int N_MISSILES = 8,
    parameter int N_BARRIERS = 4,
    parameter int PIX_W      = sprite_pkg::PIX_W_DEF
) (
    input logic               vga_clk_i,
    input logic               vga_rst_i,
    sprite_compositor_if.slave bus
);
    import sprite_pkg::*;

    localparam int SCORE_W = score_w(N_ALIENS);

    game_state_t           state_q, state_d;
    logic                  landed_seen_q;
    logic                  restart_seen_q;
    logic                  revive;
    logic [SCORE_W-1:0]    score_q;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [N_ALIENS-1:0]   alive;
    logic [N_MISSILES-1:0] missile_hit;
    logic                  kill;

    collision_unit #(
        .N_ALIENS   (N_ALIENS),
        .N_MISSILES (N_MISSILES)
    ) u_collision (
        .clk            (vga_clk_i),
        .rst            (vga_rst_i),
        .play_en        (state_q == PLAY),
        .frame_start    (bus.frame_start_i),
        .revive         (revive),
        .alien_active   (bus.alien_active_i),
        .missile_active (bus.missile_active_i),
        .barrier_hit    (|bus.barrier_active_i),
        .alive          (alive),
        .missile_hit    (missile_hit),
        .kill           (kill)
    );

    // State changes only on frame_start so a frame is never split between screens.
    always_comb begin
        state_d = state_q;
        revive  = 1'b0;
        case (state_q)
            PLAY: begin
                if (bus.frame_start_i) begin
                    if (alive == '0)
                        state_d = WIN;
                    else if (landed_seen_q || bus.landed_i)
                        state_d = LOSE;
                end
            end
            WIN, LOSE: begin
                if (bus.frame_start_i && (restart_seen_q || bus.restart_i)) begin
                    state_d = PLAY;
                    revive  = 1'b1;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_comb begin
        pix_d = '0;
        if (bus.video_on_i) begin
            case (state_q)
                PLAY: begin
                    if (|(bus.alien_active_i & alive))
                        pix_d = bus.alien_pix_i;
                    else if (bus.player_active_i)
                        pix_d = bus.player_pix_i;
                    else if (|bus.missile_active_i)
                        pix_d = bus.missile_pix_i;
                    else if (|bus.barrier_active_i)
                        pix_d = bus.barrier_pix_i;
                    else
                        pix_d = bus.bg_pix_i;
                end
                WIN:     pix_d = bus.win_pix_i;
                LOSE:    pix_d = bus.lose_pix_i;
                default: pix_d = '0;
            endcase
        end
    end

    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            state_q        <= PLAY;
            landed_seen_q  <= 1'b0;
            restart_seen_q <= 1'b0;
            score_q        <= '0;
            pix_q          <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            if (revive) begin
                landed_seen_q  <= 1'b0;
                restart_seen_q <= 1'b0;
                score_q        <= '0;
            end else begin
                if (state_q == PLAY && bus.landed_i)
                    landed_seen_q <= 1'b1;
                if (state_q != PLAY && bus.restart_i)
                    restart_seen_q <= 1'b1;
                if (kill && score_q < SCORE_W'(N_ALIENS))
                    score_q <= score_q + SCORE_W'(1);
            end
        end
    end

    assign bus.pix_o         = pix_q;
    assign bus.alive_o       = alive;
    assign bus.missile_hit_o = missile_hit;
    assign bus.score_o       = score_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: kills, spent mask, priority picks,
// barrier hits, WIN/LOSE/restart flow and blanking.
module tb_sprite_compositor;

    logic vga_clk = 1'b0;
    logic vga_rst = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    sprite_compositor_if bus ();

    sprite_compositor dut (
        .vga_clk_i (vga_clk),
        .vga_rst_i (vga_rst),
        .bus       (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic apply_stimulus();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.video_on_i       = 1'b0;
        bus.frame_start_i    = 1'b0;
        bus.alien_active_i   = '0;
        bus.alien_pix_i      = 4'hA;
        bus.player_active_i  = 1'b0;
        bus.player_pix_i     = 4'hB;
        bus.missile_active_i = '0;
        bus.missile_pix_i    = 4'hC;
        bus.barrier_active_i = '0;
        bus.barrier_pix_i    = 4'hD;
        bus.bg_pix_i         = 4'h3;
        bus.win_pix_i        = 4'h5;
        bus.lose_pix_i       = 4'h9;
        bus.landed_i         = 1'b0;
        bus.restart_i        = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        bus.frame_start_i = 1'b1;
        apply_stimulus();
        bus.frame_start_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        apply_stimulus();
        apply_stimulus();
        check_output("rst_pix", 32'(bus.pix_o), 32'h0);
        check_output("rst_alive", 32'(bus.alive_o), 32'h7FFF);
        check_output("rst_hit", 32'(bus.missile_hit_o), 32'h0);
        check_output("rst_score", 32'(bus.score_o), 32'h0);
        check_output("rst_state", 32'(bus.state_o), 32'h0);
        vga_rst = 1'b0;

        bus.video_on_i = 1'b1;
        apply_stimulus();
        check_output("bg_pix", 32'(bus.pix_o), 32'h3);

        bus.alien_active_i   = 15'h0004;
        bus.missile_active_i = 8'h20;
        apply_stimulus();
        check_output("kill2_pix", 32'(bus.pix_o), 32'hA);
        check_output("kill2_alive", 32'(bus.alive_o), 32'h7FFB);
        check_output("kill2_hit", 32'(bus.missile_hit_o), 32'h20);
        check_output("kill2_score", 32'(bus.score_o), 32'h1);

        bus.missile_active_i = '0;
        apply_stimulus();
        check_output("hit_pulse_end", 32'(bus.missile_hit_o), 32'h0);
        check_output("dead_alien_bg", 32'(bus.pix_o), 32'h3);

        bus.alien_active_i   = 15'h0008;
        bus.missile_active_i = 8'h20;
        apply_stimulus();
        check_output("spent_alive", 32'(bus.alive_o), 32'h7FFB);
        check_output("spent_hit", 32'(bus.missile_hit_o), 32'h0);
        check_output("spent_score", 32'(bus.score_o), 32'h1);

        clear_inputs();
        bus.video_on_i = 1'b1;
        frame_pulse();
        bus.alien_active_i   = 15'h0008;
        bus.missile_active_i = 8'h20;
        apply_stimulus();
        check_output("kill3_alive", 32'(bus.alive_o), 32'h7FF3);
        check_output("kill3_hit", 32'(bus.missile_hit_o), 32'h20);
        check_output("kill3_score", 32'(bus.score_o), 32'h2);

        bus.alien_active_i   = 15'h0006;
        bus.missile_active_i = 8'h12;
        apply_stimulus();
        check_output("multi_alive", 32'(bus.alive_o), 32'h7FF1);
        check_output("multi_hit", 32'(bus.missile_hit_o), 32'h02);
        check_output("multi_score", 32'(bus.score_o), 32'h3);

        bus.alien_active_i   = '0;
        bus.missile_active_i = 8'h01;
        bus.barrier_active_i = 4'h4;
        apply_stimulus();
        check_output("barrier_hit", 32'(bus.missile_hit_o), 32'h01);
        check_output("barrier_alive", 32'(bus.alive_o), 32'h7FF1);
        check_output("barrier_score", 32'(bus.score_o), 32'h3);
        bus.barrier_active_i = '0;
        bus.missile_active_i = '0;

        for (int i = 0; i < 12; i++) begin
            int k;
            k = (i == 0) ? 0 : i + 3;
            frame_pulse();
            if (i == 11) begin
                bus.landed_i = 1'b1;
                apply_stimulus();
                bus.landed_i = 1'b0;
            end
            bus.alien_active_i   = 15'(1 << k);
            bus.missile_active_i = 8'h01;
            apply_stimulus();
            bus.alien_active_i   = '0;
            bus.missile_active_i = '0;
        end
        check_output("all_dead_alive", 32'(bus.alive_o), 32'h0);
        check_output("all_dead_score", 32'(bus.score_o), 32'd15);
        apply_stimulus();
        check_output("win_wait_state", 32'(bus.state_o), 32'h0);

        frame_pulse();
        check_output("win_state", 32'(bus.state_o), 32'h1);
        apply_stimulus();
        check_output("win_pix", 32'(bus.pix_o), 32'h5);

        bus.restart_i = 1'b1;
        apply_stimulus();
        bus.restart_i = 1'b0;
        frame_pulse();
        check_output("restart1_state", 32'(bus.state_o), 32'h0);
        check_output("restart1_alive", 32'(bus.alive_o), 32'h7FFF);
        check_output("restart1_score", 32'(bus.score_o), 32'h0);

        bus.restart_i = 1'b1;
        apply_stimulus();
        bus.restart_i = 1'b0;
        bus.landed_i  = 1'b1;
        apply_stimulus();
        bus.landed_i  = 1'b0;
        check_output("landed_wait_state", 32'(bus.state_o), 32'h0);
        frame_pulse();
        check_output("lose_state", 32'(bus.state_o), 32'h2);
        apply_stimulus();
        check_output("lose_pix", 32'(bus.pix_o), 32'h9);
        frame_pulse();
        check_output("lose_hold_state", 32'(bus.state_o), 32'h2);

        bus.restart_i = 1'b1;
        apply_stimulus();
        bus.restart_i = 1'b0;
        frame_pulse();
        check_output("restart2_state", 32'(bus.state_o), 32'h0);
        check_output("restart2_alive", 32'(bus.alive_o), 32'h7FFF);
        check_output("restart2_score", 32'(bus.score_o), 32'h0);

        bus.video_on_i = 1'b0;
        apply_stimulus();
        check_output("blank_pix", 32'(bus.pix_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
